// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared register map, FSM encoding and parameter check for the interrupt controller
package irq_pkg;

    localparam logic [1:0] REG_PEND = 2'd0;
    localparam logic [1:0] REG_MASK = 2'd1;
    localparam logic [1:0] REG_VEC  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int VEC_BUSY_BIT = 31;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SERVICE = 1'b1
    } irq_state_e;

    function automatic bit ids_legal(input int nsrc, input int idw);
        return (nsrc >= 1) && (nsrc <= 8) && ((1 << idw) >= nsrc);
    endfunction

endpackage

// File: rtl/irq_ctrl_mm_if.sv
// rtl/irq_ctrl_mm_if.sv - register bus (A/WE/WD/RD) shared by the SoC slave units
interface irq_ctrl_mm_if;

    logic [1:0]  A;
    logic        WE;
    logic [31:0] WD;
    logic [31:0] RD;

    modport master (output A, output WE, output WD, input RD);
    modport slave  (input A, input WE, input WD, output RD);

endinterface

// File: rtl/irq_ctrl_mm_prio_enc.sv
// rtl/irq_ctrl_mm_prio_enc.sv - lowest-index-wins priority encoder
module prio_enc #(
    parameter int NSRC = 4,
    parameter int IDW  = 3
) (
    input  logic [NSRC-1:0] req,
    output logic [IDW-1:0]  id,
    output logic            valid
);

    // Walk from the top down so the lowest set index is the last assignment.
    always_comb begin
        id    = '0;
        valid = |req;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl_mm.sv
// rtl/irq_ctrl_mm.sv - memory-mapped interrupt controller with pend/mask/claim/EOI
module irq_ctrl_mm
    import irq_pkg::*;
#(
    parameter int NSRC = 4,
    parameter int IDW  = 3
) (
    input  logic             clk,
    input  logic             rst,
    irq_ctrl_mm_if.slave     bus,
    input  logic [NSRC-1:0]  src,
    input  logic             iack,
    output logic             irq,
    output logic [IDW-1:0]   addr,
    output logic             busy
);

    if (!ids_legal(NSRC, IDW)) begin : g_bad_params
        $error("irq_ctrl_mm: NSRC must be 1..8 and 2^IDW >= NSRC");
    end

    irq_state_e      state_q, state_d;
    logic [NSRC-1:0] src_q, src_d;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic            en_q, en_d;
    logic            irq_q, irq_d;
    logic [IDW-1:0]  addr_q, addr_d;

    logic            in_service;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] claim_clr;
    logic [NSRC-1:0] active;
    logic [IDW-1:0]  sel_id;
    logic            sel_valid;
    logic            eoi;
    logic            claim;
    logic [31:0]     rd_data;
    logic            unused_wd;

    assign active = pend_q & mask_q;

    prio_enc #(.NSRC(NSRC), .IDW(IDW)) u_prio (
        .req   (active),
        .id    (sel_id),
        .valid (sel_valid)
    );

    assign rise  = src & ~src_q;
    assign eoi   = bus.WE && (bus.A == REG_VEC);
    // An EOI in the same cycle wins; the CPU must re-acknowledge afterwards.
    assign claim = iack && irq_q && !in_service && !eoi && sel_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (claim) state_d = ST_SERVICE;
            ST_SERVICE: if (eoi)   state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_service = (state_q == ST_SERVICE);
    end

    always_comb begin
        w1c = '0;
        if (bus.WE && (bus.A == REG_PEND)) begin
            w1c = bus.WD[NSRC-1:0];
        end
        claim_clr = claim ? (NSRC'(1) << sel_id) : '0;

        src_d  = src;
        pend_d = (pend_q & ~w1c & ~claim_clr) | rise;
        mask_d = (bus.WE && (bus.A == REG_MASK)) ? bus.WD[NSRC-1:0] : mask_q;
        en_d   = (bus.WE && (bus.A == REG_CTRL)) ? bus.WD[0] : en_q;
        addr_d = claim ? sel_id : addr_q;
        // Claim forces irq low right away so the CPU never sees a stale request.
        irq_d  = en_q && !in_service && !claim && (|active);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q  <= '0;
            pend_q <= '0;
            mask_q <= '0;
            en_q   <= 1'b0;
            irq_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            src_q  <= src_d;
            pend_q <= pend_d;
            mask_q <= mask_d;
            en_q   <= en_d;
            irq_q  <= irq_d;
            addr_q <= addr_d;
        end
    end

    always_comb begin
        rd_data = '0;
        case (bus.A)
            REG_PEND: rd_data[NSRC-1:0] = pend_q;
            REG_MASK: rd_data[NSRC-1:0] = mask_q;
            REG_VEC: begin
                rd_data[VEC_BUSY_BIT] = in_service;
                rd_data[IDW-1:0]      = addr_q;
            end
            REG_CTRL: rd_data[0] = en_q;
            default:  rd_data = '0;
        endcase
    end

    assign bus.RD    = rd_data;
    assign irq       = irq_q;
    assign addr      = addr_q;
    assign busy      = in_service;
    assign unused_wd = ^bus.WD;

endmodule
